tff_count_ctrl: RTL and testbench

- Sequencer for a bank of WIDTH toggle flip-flops; drives per-bit toggle enables so the bank counts as a synchronous modulo-N up/down counter.
- Holds the T-FF bank state internally (q <= q ^ t_vec each clk edge).
- Provides start/hold/stop control, one-shot or free-running mode, and wrap/done status.
- Sits between a control FSM (or CPU-side register block) and any logic that consumes the count.

---
 rtl/tff_count_ctrl.sv | 147 ++++++++++++++
 tb/tb_tff_count_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequencer for a bank of WIDTH toggle flip-flops. It drives
// per-bit toggle enables so that the bank counts as a synchronous modulo-N
// up/down counter. Start/hold/stop control, one-shot or free-running mode.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin a session (sampled in IDLE only)
//   hold          pause counting while high
//   stop          abort session, q retained
//   dir_up        1 = up, 0 = down (latched at start)
//   oneshot       1 = stop at terminal count, 0 = wrap (latched at start)
//   mod_val       modulus N, 0 means 2^WIDTH (latched at start)
//   t_vec         combinational toggle mask applied at the next edge
//   q             T-FF bank state
//   busy          high in RUN or HOLD
//   wrap          one-cycle pulse after a terminal reload edge
//   done          one-cycle pulse on entry to DONE
//
// Optional build macro TFF_COUNT_CTRL_GRAY_EN: q becomes a Gray-coded count
// of an internal binary counter, so exactly one bit toggles per step.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  input  logic             dir_up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic             dir_q, os_q;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] last;      // N-1; mod 0 wraps to all-ones = 2^WIDTH-1
  logic [WIDTH-1:0] cnt;       // binary count the step logic works on
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] step_mask;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] load_val;
  logic             term;
  logic             adv;       // RUN and neither stop nor hold: a count edge

  function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] x);
`ifdef TFF_COUNT_CTRL_GRAY_EN
    return x ^ (x >> 1);
`else
    return x;
`endif
  endfunction

`ifdef TFF_COUNT_CTRL_GRAY_EN
  logic [WIDTH-1:0] b;
  assign cnt = b;
  always_ff @(posedge clk) begin
    if (rst)                            b <= '0;
    else if (state == S_IDLE && start)  b <= load_val;
    else                                b <= cnt_nx;
  end
`else
  assign cnt = q;
`endif

  assign last     = mod_q - WIDTH'(1);
  assign load_val = dir_up ? '0 : (mod_val - WIDTH'(1));
  assign reload   = dir_q ? '0 : last;
  assign term     = dir_q ? (cnt == last) : (cnt == '0);
  assign adv      = (state == S_RUN) && !stop && !hold;
  assign busy     = (state == S_RUN) || (state == S_HOLD);

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up)
  // or all lower bits are 0 (down); bit 0 always toggles.
  always_comb begin
    logic c;
    step_mask = '0;
    c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_mask[i] = c;
      c = c & (dir_q ? cnt[i] : ~cnt[i]);
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (adv) begin
      if (term) begin
        if (!os_q) cnt_nx = reload;
      end else begin
        cnt_nx = cnt ^ step_mask;
      end
    end
  end

  // q always equals enc(cnt), so this covers the step, the reload and
  // the idle/hold/done cases (t_vec = 0) uniformly.
  assign t_vec = enc(cnt_nx) ^ q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      dir_q <= 1'b0;
      os_q  <= 1'b0;
      mod_q <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      wrap <= adv && term && !os_q;
      done <= adv && term && os_q;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            dir_q <= dir_up;
            os_q  <= oneshot;
            mod_q <= mod_val;
            q     <= enc(load_val);
          end
        end
        S_RUN: begin
          q <= q ^ t_vec;
          if (stop)                state <= S_IDLE;
          else if (hold)           state <= S_HOLD;
          else if (term && os_q)   state <= S_DONE;
        end
        S_HOLD: begin
          if (stop)       state <= S_IDLE;
          else if (!hold) state <= S_RUN;
        end
        default: state <= S_IDLE;  // DONE lasts one cycle
      endcase
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomized bench for tff_count_ctrl with a session-level reference model.
module tb_tff_count_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, hold, stop, dir_up, oneshot;
  logic [W-1:0] mod_val, t_vec, q;
  logic         busy, wrap, done;

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 run, 2 hold, 3 done
  int m_mode, m_cnt, m_n, m_up, m_os, m_wrap, m_done;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
    .dir_up(dir_up), .oneshot(oneshot), .mod_val(mod_val),
    .t_vec(t_vec), .q(q), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int enc(input int v);
`ifdef TFF_COUNT_CTRL_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  function automatic int popc(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += v[i];
    return n;
  endfunction

  // One clock: drive inputs after negedge, check, then advance model at posedge.
  task automatic step(input logic r, st, h, sp, du, os, input logic [W-1:0] mv);
    int nx_mode, nx_cnt, nx_wrap, nx_done, term_v;
    rst = r; start = st; hold = h; stop = sp; dir_up = du; oneshot = os; mod_val = mv;
    #1;
    chk("q",    q,    enc(m_cnt));
    chk("busy", busy, (m_mode == 1 || m_mode == 2));
    chk("wrap", wrap, m_wrap);
    chk("done", done, m_done);
    nx_mode = m_mode; nx_cnt = m_cnt; nx_wrap = 0; nx_done = 0;
    case (m_mode)
      0: if (st) begin
           m_up = du; m_os = os; m_n = (mv == 0) ? (1 << W) : mv;
           nx_cnt = du ? 0 : m_n - 1; nx_mode = 1;
         end
      1: if (sp) nx_mode = 0;
         else if (h) nx_mode = 2;
         else begin
           term_v = m_up ? m_n - 1 : 0;
           if (m_cnt == term_v) begin
             if (m_os) begin nx_mode = 3; nx_done = 1; end
             else begin nx_cnt = m_up ? 0 : m_n - 1; nx_wrap = 1; end
           end else nx_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
         end
      2: if (sp) nx_mode = 0; else if (!h) nx_mode = 1;
      default: nx_mode = 0;
    endcase
    if (!r) begin
      // t_vec only moves q in RUN; the IDLE load is a direct write
      chk("t_vec", t_vec, (m_mode == 1) ? (enc(nx_cnt) ^ enc(m_cnt)) : 0);
`ifdef TFF_COUNT_CTRL_GRAY_EN
      if (m_mode == 1 && nx_cnt != m_cnt) chk("gray_one_bit", popc(t_vec), 1);
`endif
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_cnt = 0; m_wrap = 0; m_done = 0; m_up = 0; m_os = 0; m_n = 1 << W;
    end else begin
      m_mode = nx_mode; m_cnt = nx_cnt; m_wrap = nx_wrap; m_done = nx_done;
    end
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_mode = 0; m_cnt = 0; m_wrap = 0; m_done = 0; m_up = 0; m_os = 0; m_n = 1 << W;
    rst = 1; start = 0; hold = 0; stop = 0; dir_up = 0; oneshot = 0; mod_val = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_q", q, 0); chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0); chk("rst_done", done, 0);

    // up mod 10 free-running; a start mid-run is ignored
    step(0, 1, 0, 0, 1, 0, 4'd10);
    for (int i = 0; i < 24; i++) step(0, (i == 7), 0, 0, 0, 1, 4'd3);
    // hold at q=5 for 3 cycles
    while (m_cnt != 5) step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
    idle_n(3);
    // stop + hold at q=3
    while (m_cnt != 3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle_n(2);

    // down, mod 0 (=16), oneshot
    step(0, 1, 0, 0, 0, 1, 4'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);

    // N=1 free-running, then reset mid-run
    step(0, 1, 0, 0, 1, 0, 4'd1);
    idle_n(5);
    step(1, 0, 0, 0, 0, 0, 0);
    idle_n(2);

    // up mod 16 wrap (Gray single-bit check covers 8->0)
    step(0, 1, 0, 0, 1, 0, 4'd0);
    idle_n(34);

    // random sessions
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
